// File: rtl/note_synth_pkg.sv
// rtl/note_synth_pkg.sv - shared FSM states, phase increments and sample width for note_synth.
package note_synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int SAMPLE_W = 16;

  // 24-bit phase steps for a 48 kHz sample rate, C4..F4.
  localparam logic [23:0] INC0 = 24'd0;
  localparam logic [23:0] INC1 = 24'd91446;
  localparam logic [23:0] INC2 = 24'd102642;
  localparam logic [23:0] INC3 = 24'd115214;
  localparam logic [23:0] INC4 = 24'd122065;

  function automatic logic [23:0] note_inc(input logic [2:0] note);
    case (note)
      3'd1:    return INC1;
      3'd2:    return INC2;
      3'd3:    return INC3;
      3'd4:    return INC4;
      default: return INC0;
    endcase
  endfunction

endpackage

// File: rtl/note_synth_pad_debounce.sv
// rtl/note_synth_pad_debounce.sv - per-frame pad hit collection and saturating debounce counters.
module pad_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_sound_num,
  input  logic       i_frame_end,
  output logic [3:0] o_pressed
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_FRAMES);

  logic [3:0] r_frame_hit;
  logic [3:0] r_pressed;
  logic [3:0] r_cnt      [4];
  logic [3:0] w_cnt_next [4];
  logic [3:0] w_hit_now;
  logic [3:0] w_hit;

  always_comb begin
    w_hit_now = 4'b0000;
    case (i_sound_num)
      3'd1:    w_hit_now = 4'b0001;
      3'd2:    w_hit_now = 4'b0010;
      3'd3:    w_hit_now = 4'b0100;
      3'd4:    w_hit_now = 4'b1000;
      default: w_hit_now = 4'b0000;
    endcase
  end

  // A hit landing on the frame_end cycle still belongs to the closing frame.
  assign w_hit = r_frame_hit | w_hit_now;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_cnt_next[k] = 4'd0;
      if (w_hit[k]) begin
        w_cnt_next[k] = (r_cnt[k] == CNT_MAX) ? CNT_MAX : r_cnt[k] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_hit <= 4'b0000;
      r_pressed   <= 4'b0000;
      for (int k = 0; k < 4; k++) r_cnt[k] <= 4'd0;
    end else if (i_frame_end) begin
      r_frame_hit <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_cnt[k]     <= w_cnt_next[k];
        r_pressed[k] <= (w_cnt_next[k] == CNT_MAX);
      end
    end else begin
      r_frame_hit <= w_hit;
    end
  end

  assign o_pressed = r_pressed;

endmodule

// File: rtl/note_synth.sv
// rtl/note_synth.sv - debounced pad-to-square-wave note synthesizer, one voice.
// Optional release tail enabled by defining NOTE_SYNTH_RELEASE_EN.
module note_synth #(
  parameter int                 DEBOUNCE_FRAMES = 3,
  parameter logic signed [15:0] AMP             = 16'sh2000,
  parameter logic [15:0]        DECAY_STEP      = 16'd64,
  parameter int                 PHASE_W         = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_sound_num,
  input  logic        i_frame_end,
  input  logic        i_dac_req,
  output logic [15:0] o_sample,
  output logic        o_sample_valid,
  output logic [2:0]  o_note,
  output logic        o_busy
);
  import note_synth_pkg::*;

  state_t               r_state, w_state_next;
  logic [PHASE_W-1:0]   r_phase, w_phase_next, w_phase_step;
  logic [SAMPLE_W-1:0]  r_amp, w_amp_next, w_sample_amp, w_sample;
  logic [2:0]           r_note, w_note_next, w_sel;
  logic [SAMPLE_W-1:0]  r_sample;
  logic                 r_valid;
  logic                 r_eval;
  logic [3:0]           w_pressed;
  logic                 w_any;
`ifdef NOTE_SYNTH_RELEASE_EN
  logic [SAMPLE_W-1:0]  w_amp_dec;
`endif

  pad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_sound_num(i_sound_num),
    .i_frame_end(i_frame_end),
    .o_pressed  (w_pressed)
  );

  assign w_any = |w_pressed;

  always_comb begin
    w_sel = 3'd0;
    if      (w_pressed[0]) w_sel = 3'd1;
    else if (w_pressed[1]) w_sel = 3'd2;
    else if (w_pressed[2]) w_sel = 3'd3;
    else if (w_pressed[3]) w_sel = 3'd4;
  end

`ifdef NOTE_SYNTH_RELEASE_EN
  assign w_amp_dec = (r_amp > DECAY_STEP) ? r_amp - DECAY_STEP : '0;
`endif

  assign w_phase_step = r_phase + PHASE_W'(note_inc(r_note));

  always_comb begin
    w_state_next = r_state;
    w_note_next  = r_note;
    w_amp_next   = r_amp;
    w_phase_next = i_dac_req ? w_phase_step : r_phase;
    w_sample_amp = r_amp;
    case (r_state)
      IDLE: begin
        if (r_eval && w_any) begin
          w_state_next = PLAY;
          w_phase_next = '0;
          w_amp_next   = AMP;
          w_note_next  = w_sel;
        end
      end
      PLAY: begin
        if (r_eval) begin
          if (w_any) begin
            w_note_next = w_sel;
          end else begin
`ifdef NOTE_SYNTH_RELEASE_EN
            w_state_next = RELEASE;
`else
            w_state_next = IDLE;
            w_amp_next   = '0;
            w_note_next  = 3'd0;
`endif
          end
        end
      end
`ifdef NOTE_SYNTH_RELEASE_EN
      RELEASE: begin
        // The sample on a request always reflects the decayed amplitude.
        w_sample_amp = w_amp_dec;
        if (r_eval && w_any) begin
          w_state_next = PLAY;
          w_amp_next   = AMP;
          w_note_next  = w_sel;
        end else if (i_dac_req) begin
          w_amp_next = w_amp_dec;
          if (w_amp_dec == '0) begin
            w_state_next = IDLE;
            w_note_next  = 3'd0;
          end
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Sample is taken from the pre-transition state on a colliding request.
  always_comb begin
    w_sample = '0;
    if (r_state != IDLE) begin
      w_sample = w_phase_step[PHASE_W-1] ? (~w_sample_amp + 16'd1) : w_sample_amp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_amp    <= '0;
      r_note   <= 3'd0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_eval   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_amp   <= w_amp_next;
      r_note  <= w_note_next;
      r_valid <= i_dac_req;
      r_eval  <= i_frame_end;
      if (i_dac_req) r_sample <= w_sample;
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_note         = r_note;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_note_synth.sv
// tb/tb_note_synth.sv - table-driven and sequence checks for note_synth.
module tb_note_synth;

  localparam logic [23:0] INC1 = 24'd91446;
  localparam logic [23:0] INC2 = 24'd102642;
  localparam logic [23:0] INC3 = 24'd115214;
  localparam logic [15:0] AMPV = 16'h2000;

  logic        clk;
  logic        rst;
  logic [2:0]  i_sound_num;
  logic        i_frame_end;
  logic        i_dac_req;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic [2:0]  o_note;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [23:0] ph;
  logic [15:0] amp;

  note_synth dut (
    .clk           (clk),
    .rst           (rst),
    .i_sound_num   (i_sound_num),
    .i_frame_end   (i_frame_end),
    .i_dac_req     (i_dac_req),
    .o_sample      (o_sample),
    .o_sample_valid(o_sample_valid),
    .o_note        (o_note),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] a;
    logic [8:0] b;
    logic [2:0] fe;
    logic [2:0] note;
    logic       busy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One frame: two hit cycles, then frame_end (with its own code), then the evaluation cycle.
  task automatic frame(input logic [2:0] a, input logic [2:0] b, input logic [2:0] fe);
    i_sound_num = a;
    tick();
    i_sound_num = b;
    tick();
    i_sound_num = fe;
    i_frame_end = 1'b1;
    tick();
    i_sound_num = 3'd0;
    i_frame_end = 1'b0;
    tick();
  endtask

  task automatic dac(input string nm, input logic [15:0] exp);
    i_dac_req = 1'b1;
    tick();
    i_dac_req = 1'b0;
    chk({nm, "_valid"}, {31'd0, o_sample_valid}, 32'd1);
    chk({nm, "_sample"}, {16'd0, o_sample}, {16'd0, exp});
    tick();
    chk({nm, "_pulse"}, {31'd0, o_sample_valid}, 32'd0);
  endtask

  function automatic logic [15:0] sq(input logic [23:0] p, input logic [15:0] a);
    return p[23] ? (~a + 16'd1) : a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: {3'd2, 3'd2, 3'd2}, b: 9'd0,                fe: 3'd0, note: 3'd2, busy: 1'b1};
    vecs[1] = '{a: {3'd2, 3'd0, 3'd2}, b: 9'd0,                fe: 3'd0, note: 3'd0, busy: 1'b0};
    vecs[2] = '{a: {3'd6, 3'd6, 3'd6}, b: {3'd6, 3'd6, 3'd6}, fe: 3'd6, note: 3'd0, busy: 1'b0};
    vecs[3] = '{a: {3'd1, 3'd1, 3'd1}, b: 9'd0,                fe: 3'd0, note: 3'd1, busy: 1'b1};
    vecs[4] = '{a: {3'd4, 3'd4, 3'd4}, b: {3'd3, 3'd3, 3'd3}, fe: 3'd0, note: 3'd3, busy: 1'b1};
    vecs[5] = '{a: 9'd0,                b: 9'd0,                fe: 3'd4, note: 3'd4, busy: 1'b1};
    vecs[6] = '{a: {3'd2, 3'd2, 3'd0}, b: 9'd0,                fe: 3'd0, note: 3'd0, busy: 1'b0};
    vecs[7] = '{a: {3'd7, 3'd5, 3'd0}, b: {3'd3, 3'd3, 3'd3}, fe: 3'd0, note: 3'd3, busy: 1'b1};
    vecs[8] = '{a: {3'd3, 3'd3, 3'd3}, b: {3'd1, 3'd1, 3'd1}, fe: 3'd0, note: 3'd1, busy: 1'b1};
    vecs[9] = '{a: 9'd0,                b: 9'd0,                fe: 3'd0, note: 3'd0, busy: 1'b0};

    rst = 1'b0;
    i_sound_num = 3'd0;
    i_frame_end = 1'b0;
    i_dac_req = 1'b0;

    // Reset held with requests toggling.
    for (int i = 0; i < 4; i++) begin
      i_dac_req = i[0];
      tick();
      chk("rst_sample", {16'd0, o_sample}, 32'd0);
      chk("rst_valid", {31'd0, o_sample_valid}, 32'd0);
      chk("rst_note", {29'd0, o_note}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
    end
    i_dac_req = 1'b0;
    rst = 1'b1;
    tick();
    dac("idle_dac", 16'h0000);

    // Debounce and priority vectors, each from reset.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int f = 0; f < 3; f++) frame(vecs[v].a[3*f +: 3], vecs[v].b[3*f +: 3], vecs[v].fe);
      chk($sformatf("vec%0d_note", v), {29'd0, o_note}, {29'd0, vecs[v].note});
      chk($sformatf("vec%0d_busy", v), {31'd0, o_busy}, {31'd0, vecs[v].busy});
    end

    // Tone on pad 1 from a fresh start: phase begins at zero.
    do_reset();
    for (int f = 0; f < 3; f++) frame(3'd1, 3'd0, 3'd0);
    chk("tone_note", {29'd0, o_note}, 32'd1);
    ph = 24'd0;
    for (int n = 0; n < 100; n++) begin
      ph = ph + INC1;
      dac($sformatf("tone%0d", n), sq(ph, AMPV));
    end

    // Pads 1 and 3 held: pad 1 wins; dropping pad 1 hands over to pad 3 with phase intact.
    for (int f = 0; f < 3; f++) frame(3'd1, 3'd3, 3'd0);
    chk("prio_both", {29'd0, o_note}, 32'd1);
    frame(3'd3, 3'd0, 3'd0);
    chk("prio_handover", {29'd0, o_note}, 32'd3);
    chk("prio_busy", {31'd0, o_busy}, 32'd1);
    for (int n = 0; n < 10; n++) begin
      ph = ph + INC3;
      dac($sformatf("cont%0d", n), sq(ph, AMPV));
    end

`ifdef NOTE_SYNTH_RELEASE_EN
    frame(3'd0, 3'd0, 3'd0);
    chk("rel_busy", {31'd0, o_busy}, 32'd1);
    chk("rel_note_held", {29'd0, o_note}, 32'd3);
    amp = AMPV;
    for (int n = 0; n < 128; n++) begin
      ph = ph + INC3;
      amp = amp - 16'd64;
      dac($sformatf("rel%0d", n), sq(ph, amp));
    end
    chk("rel_done_busy", {31'd0, o_busy}, 32'd0);
    chk("rel_done_note", {29'd0, o_note}, 32'd0);

    // Re-press during the tail restores full amplitude without a phase reset.
    for (int f = 0; f < 3; f++) frame(3'd2, 3'd0, 3'd0);
    ph = 24'd0;
    frame(3'd0, 3'd0, 3'd0);
    amp = AMPV;
    for (int n = 0; n < 5; n++) begin
      ph = ph + INC2;
      amp = amp - 16'd64;
      dac($sformatf("tail%0d", n), sq(ph, amp));
    end
    for (int f = 0; f < 3; f++) frame(3'd2, 3'd0, 3'd0);
    chk("repress_note", {29'd0, o_note}, 32'd2);
    chk("repress_busy", {31'd0, o_busy}, 32'd1);
    for (int n = 0; n < 3; n++) begin
      ph = ph + INC2;
      dac($sformatf("repress%0d", n), sq(ph, AMPV));
    end
`else
    frame(3'd0, 3'd0, 3'd0);
    chk("off_busy", {31'd0, o_busy}, 32'd0);
    chk("off_note", {29'd0, o_note}, 32'd0);
    dac("off_dac", 16'h0000);
    amp = 16'd0;
`endif

    // Reset mid-note takes effect without a clock edge.
    for (int f = 0; f < 3; f++) frame(3'd4, 3'd0, 3'd0);
    chk("mid_note", {29'd0, o_note}, 32'd4);
    dac("mid_dac", 16'h2000);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_note", {29'd0, o_note}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_sample", {16'd0, o_sample}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
